sine_voice_scheduler: RTL and testbench

Time-multiplexes one quarter-sine expander (`SineExpander`, 8-bit phase address in, 11-bit unsigned sample out) across four arpeggiator voices. On each sample tick it advances each voice's phase accumulator and issues that voice's address to the expander. It then waits out the expander's pipeline latency, captures the sample, and accumulates the four results into one mixed 11-bit output sample. It sits between the note/sequencer logic, which writes phase increments, and the audio output stage, which consumes `mix_out`.

---
 rtl/sine_voice_scheduler.sv | 110 +++++++++++
 tb/tb_sine_voice_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sine_voice_scheduler.sv
// Four-voice sine scheduler: time-multiplexes one pipelined quarter-sine
// expander across four phase accumulators and mixes the results per sample tick.
module sine_voice_scheduler #(
  parameter int LAT     = 3,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic [3:0]         voice_en,
  input  logic               inc_we,
  input  logic [1:0]         inc_sel,
  input  logic [PHASE_W-1:0] inc_data,
  output logic [7:0]         sine_addr,
  input  logic [10:0]        sine_dout,
  output logic [10:0]        mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun,
  input  logic               overrun_clr
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(LAT - 1);

  state_t             state, state_next;
  logic [PHASE_W-1:0] phase [4];
  logic [PHASE_W-1:0] inc   [4];
  logic [12:0]        acc;
  logic [1:0]         v;
  logic [CW-1:0]      wait_cnt;
  logic               en_cur;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_next = CAPTURE;
      CAPTURE: state_next = (v == 2'd3) ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
      acc       <= '0;
      v         <= '0;
      wait_cnt  <= '0;
      en_cur    <= 1'b0;
      sine_addr <= '0;
      mix_out   <= 11'd1024;
      mix_valid <= 1'b0;
    end else begin
      if (inc_we) inc[inc_sel] <= inc_data;
      mix_valid <= (state == DONE);
      case (state)
        IDLE: begin
          if (sample_tick) begin
            v   <= '0;
            acc <= '0;
          end
        end
        ISSUE: begin
          // address comes from the pre-increment phase
          sine_addr <= phase[v][PHASE_W-1 -: 8];
          en_cur    <= voice_en[v];
          if (voice_en[v]) phase[v] <= phase[v] + inc[v];
          else             phase[v] <= '0;
          wait_cnt  <= '0;
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        CAPTURE: begin
          acc <= acc + (en_cur ? {2'b00, sine_dout} : 13'd1024);
          if (v != 2'd3) v <= v + 2'd1;
        end
        DONE: mix_out <= acc[12:2];
        default: ;
      endcase
    end
  end

  // a tick that collides with a clear still sets the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    overrun <= 1'b0;
    else if (sample_tick && busy)  overrun <= 1'b1;
    else if (overrun_clr)          overrun <= 1'b0;
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench for sine_voice_scheduler with a LAT-stage expander model
// producing dout = {addr, 3'b000}.
module tb_sine_voice_scheduler;

  localparam int LAT       = 3;
  localparam int PHASE_W   = 16;
  localparam int SLOT      = LAT + 2;
  localparam int FRAME_END = 4 * SLOT + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample_tick = 1'b0;
  logic [3:0]         voice_en = '0;
  logic               inc_we = 1'b0;
  logic [1:0]         inc_sel = '0;
  logic [PHASE_W-1:0] inc_data = '0;
  logic [7:0]         sine_addr;
  logic [10:0]        sine_dout;
  logic [10:0]        mix_out;
  logic               mix_valid;
  logic               busy;
  logic               overrun;
  logic               overrun_clr = 1'b0;

  sine_voice_scheduler #(.LAT(LAT), .PHASE_W(PHASE_W)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_en(voice_en),
    .inc_we(inc_we), .inc_sel(inc_sel), .inc_data(inc_data),
    .sine_addr(sine_addr), .sine_dout(sine_dout), .mix_out(mix_out),
    .mix_valid(mix_valid), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  logic [10:0] pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= {sine_addr, 3'b000};
  end
  assign sine_dout = pipe[LAT-1];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0]         addr_q [$];
  logic [10:0]        mix_q  [$];
  logic [PHASE_W-1:0] ref_phase [4];
  logic [PHASE_W-1:0] ref_inc   [4];
  logic               ref_ovr;

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      ref_phase[i] = '0;
      ref_inc[i]   = '0;
    end
    ref_ovr = 1'b0;
    addr_q.delete();
    mix_q.delete();
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n && mix_valid) begin
      if (mix_q.size() == 0) check("mix_unexpected", 16'd1, 16'd0);
      else begin
        e = mix_q.pop_front();
        check("mix_out", {5'd0, mix_out}, {5'd0, e});
      end
    end
  end

  task automatic write_inc(input logic [1:0] sel, input logic [15:0] data);
    @(posedge clk); #1;
    inc_we = 1'b1; inc_sel = sel; inc_data = data;
    @(posedge clk); #1;
    inc_we = 1'b0;
    ref_inc[sel] = data;
  endtask

  task automatic clear_ovr();
    @(posedge clk); #1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    ref_ovr = 1'b0;
    @(negedge clk);
    check("overrun_cleared", {15'd0, overrun}, 16'd0);
  endtask

  // one frame: model computed up front, DUT sampled at known cycle offsets
  task automatic run_frame(input logic [3:0] en, input int extra_tick, input int clr_at,
                           input bit mid_wr, input logic [1:0] wsel, input logic [15:0] wdata);
    logic [12:0] acc;
    logic [7:0]  a;
    logic [7:0]  ea;
    acc = '0;
    for (int v = 0; v < 4; v++) begin
      if (mid_wr && v == 1) ref_inc[wsel] = wdata;
      a = ref_phase[v][15:8];
      addr_q.push_back(a);
      if (en[v]) begin
        acc = acc + {2'b00, a, 3'b000};
        ref_phase[v] = ref_phase[v] + ref_inc[v];
      end else begin
        acc = acc + 13'd1024;
        ref_phase[v] = '0;
      end
    end
    mix_q.push_back(acc[12:2]);

    @(posedge clk); #1;
    voice_en = en;
    sample_tick = 1'b1;
    for (int c = 1; c <= FRAME_END + 1; c++) begin
      @(posedge clk); #1;
      sample_tick = (c == extra_tick);
      overrun_clr = (c == clr_at);
      inc_we      = (mid_wr && c == 2);
      inc_sel     = wsel;
      inc_data    = wdata;
      @(negedge clk);
      if (c == 1) begin
        check("busy_start", {15'd0, busy}, 16'd1);
        check("overrun_pre", {15'd0, overrun}, {15'd0, ref_ovr});
      end
      if (c >= 2 && (c - 2) % SLOT == 0 && (c - 2) / SLOT < 4) begin
        ea = addr_q.pop_front();
        check("sine_addr", {8'd0, sine_addr}, {8'd0, ea});
      end
      if (c == FRAME_END - 1) begin
        check("busy_done", {15'd0, busy}, 16'd1);
        check("mix_valid_early", {15'd0, mix_valid}, 16'd0);
      end
      if (c == FRAME_END) begin
        check("busy_end", {15'd0, busy}, 16'd0);
        check("mix_valid", {15'd0, mix_valid}, 16'd1);
      end
      if (c == FRAME_END + 1) check("mix_valid_clr", {15'd0, mix_valid}, 16'd0);
      if (extra_tick > 0 && c == extra_tick + 1) begin
        check("overrun_set", {15'd0, overrun}, 16'd1);
        ref_ovr = 1'b1;
      end
    end
    overrun_clr = 1'b0;
    inc_we = 1'b0;
  endtask

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", {8'd0, sine_addr}, 16'd0);
    check("rst_mix", {5'd0, mix_out}, 16'd1024);
    check("rst_valid", {15'd0, mix_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ovr", {15'd0, overrun}, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // all voices disabled: midscale output, zero addresses
    run_frame(4'b0000, 0, 0, 0, 2'd0, 16'h0);

    // single voice 0 stepping by one address per frame
    write_inc(2'd0, 16'h0100);
    repeat (3) run_frame(4'b0001, 0, 0, 0, 2'd0, 16'h0);

    // voice 2 wraps every other frame
    write_inc(2'd2, 16'h8000);
    repeat (4) run_frame(4'b0100, 0, 0, 0, 2'd0, 16'h0);

    // voice 1 restarts at phase 0 after a disabled frame
    write_inc(2'd1, 16'h0400);
    run_frame(4'b0010, 0, 0, 0, 2'd0, 16'h0);
    run_frame(4'b0010, 0, 0, 0, 2'd0, 16'h0);
    run_frame(4'b0000, 0, 0, 0, 2'd0, 16'h0);
    run_frame(4'b0010, 0, 0, 0, 2'd0, 16'h0);

    // inc[3] written during voice 0's wait is used by voice 3 the same frame
    write_inc(2'd3, 16'h0100);
    run_frame(4'b1001, 0, 0, 1, 2'd3, 16'h2000);
    run_frame(4'b1001, 0, 0, 0, 2'd0, 16'h0);

    // overrun: ignored tick, set-wins-over-clear, tick in DONE
    run_frame(4'b0001, 5, 0, 0, 2'd0, 16'h0);
    run_frame(4'b0001, 5, 5, 0, 2'd0, 16'h0);
    clear_ovr();
    run_frame(4'b0001, FRAME_END - 1, 0, 0, 2'd0, 16'h0);

    // reset mid-frame
    @(posedge clk); #1;
    voice_en = 4'b1111;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_addr", {8'd0, sine_addr}, 16'd0);
    check("midrst_mix", {5'd0, mix_out}, 16'd1024);
    check("midrst_valid", {15'd0, mix_valid}, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_ovr", {15'd0, overrun}, 16'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(4'b0001, 0, 0, 0, 2'd0, 16'h0);

    repeat (3) @(posedge clk);
    check("mix_q_empty", mix_q.size(), 16'd0);
    check("addr_q_empty", addr_q.size(), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
